// File: rtl/longop_wb_ctrl_if.sv
// Bus between Execute/Writeback, the long-latency units and the shared register-file write port.
interface longop_wb_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              m_start;
    logic [ADDR_W-1:0] m_wa3_e;
    logic              m_unit_done;
    logic [DATA_W-1:0] m_result;
    logic              fpu_start;
    logic [ADDR_W-1:0] f_wa3_e;
    logic              f_unit_done;
    logic [DATA_W-1:0] f_result;
    logic              reg_write_w;

    logic              m_cycle_busy;
    logic [ADDR_W-1:0] m_cycle_wa3;
    logic              m_cycle_done;
    logic              fpu_busy;
    logic [ADDR_W-1:0] fpu_wa3;
    logic              fpu_done;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_wa;
    logic [DATA_W-1:0] ext_wd;
    logic              wb_stall_req;

    modport slave (
        input  m_start, m_wa3_e, m_unit_done, m_result,
        input  fpu_start, f_wa3_e, f_unit_done, f_result, reg_write_w,
        output m_cycle_busy, m_cycle_wa3, m_cycle_done,
        output fpu_busy, fpu_wa3, fpu_done,
        output ext_we, ext_wa, ext_wd, wb_stall_req
    );

    modport master (
        output m_start, m_wa3_e, m_unit_done, m_result,
        output fpu_start, f_wa3_e, f_unit_done, f_result, reg_write_w,
        input  m_cycle_busy, m_cycle_wa3, m_cycle_done,
        input  fpu_busy, fpu_wa3, fpu_done,
        input  ext_we, ext_wa, ext_wd, wb_stall_req
    );
endinterface

// File: rtl/longop_wb_ctrl.sv
// Tracks MCycle/FPU in-flight ops, holds their results and arbitrates the shared write port.
//   state  | meaning
//   S_IDLE | slot free, accepts a new start
//   S_BUSY | op issued, waiting for unit done; destination latched
//   S_PEND | result held, waiting for a write-port grant
// Slot index 0 is MCycle, index 1 is FPU.
module longop_wb_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4,
    parameter int STARVE_LIM = 4
) (
    input logic              clk,
    input logic              rst_n,
    longop_wb_ctrl_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_PEND = 2'd2;
    localparam logic [3:0] LIM    = 4'(STARVE_LIM);

    logic [1:0]        state_q [2];
    logic [ADDR_W-1:0] wa3_q   [2];
    logic [DATA_W-1:0] hold_q  [2];
    logic [ADDR_W-1:0] wa3_e   [2];
    logic [DATA_W-1:0] result  [2];
    logic [1:0]        start, unit_done, pend, busy, grant;
    logic              port_free;
    logic              last_f_q;
    logic [3:0]        starve_q;

    assign start     = {bus.fpu_start, bus.m_start};
    assign unit_done = {bus.f_unit_done, bus.m_unit_done};
    assign wa3_e[0]  = bus.m_wa3_e;
    assign wa3_e[1]  = bus.f_wa3_e;
    assign result[0] = bus.m_result;
    assign result[1] = bus.f_result;

    assign pend[0]   = (state_q[0] == S_PEND);
    assign pend[1]   = (state_q[1] == S_PEND);
    assign busy[0]   = (state_q[0] != S_IDLE);
    assign busy[1]   = (state_q[1] != S_IDLE);
    assign port_free = ~bus.reg_write_w;

    // On a tie the slot that did not win the previous tie goes first.
    assign grant[0] = port_free & pend[0] & (~pend[1] | last_f_q);
    assign grant[1] = port_free & pend[1] & (~pend[0] | ~last_f_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= S_IDLE;
                wa3_q[i]   <= '0;
                hold_q[i]  <= '0;
            end
            last_f_q <= 1'b1;
            starve_q <= 4'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (state_q[i])
                    S_IDLE: if (start[i]) begin
                        state_q[i] <= S_BUSY;
                        wa3_q[i]   <= wa3_e[i];
                    end
                    S_BUSY: if (unit_done[i]) begin
                        state_q[i] <= S_PEND;
                        hold_q[i]  <= result[i];
                    end
                    S_PEND: if (grant[i]) state_q[i] <= S_IDLE;
                    default: state_q[i] <= S_IDLE;
                endcase
            end
            if ((&pend) && (|grant))
                last_f_q <= grant[1];
            if ((|pend) && !(|grant))
                starve_q <= (starve_q == 4'hf) ? 4'hf : starve_q + 4'd1;
            else
                starve_q <= 4'd0;
        end
    end

    assign bus.m_cycle_busy = busy[0];
    assign bus.m_cycle_wa3  = busy[0] ? wa3_q[0] : '0;
    assign bus.m_cycle_done = grant[0];
    assign bus.fpu_busy     = busy[1];
    assign bus.fpu_wa3      = busy[1] ? wa3_q[1] : '0;
    assign bus.fpu_done     = grant[1];
    assign bus.ext_we       = |grant;
    assign bus.ext_wa       = grant[0] ? wa3_q[0]  : (grant[1] ? wa3_q[1]  : '0);
    assign bus.ext_wd       = grant[0] ? hold_q[0] : (grant[1] ? hold_q[1] : '0);
    assign bus.wb_stall_req = (starve_q >= LIM) & (|pend) & ~(|grant);
endmodule
